alu_commit_arbiter: RTL and testbench
=====================================

# alu_commit_arbiter

Writeback/commit stage directly downstream of the execution ALUs. Collects finished results from N execution units, picks one per cycle with round-robin fairness, and drives the register-file write port. Returns a one-cycle `clear` to the granted unit so the unit can drop its result. Error-flagged results are routed to an exception output instead of being written.

## Interface
Parameters:
- N_UNITS, default core_config_pkg::ALU_COUNT (4): number of execution units arbitrated.
- XLEN, default core_config_pkg::XLEN (32): data width.
- REG_ADDR_W, default core_config_pkg::REG_ADDR_W (5): destination register index width.

Ports (clock and reset are fixed: one clock; reset is asynchronous and active-high):
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- unit_valid  in  N_UNITS  unit i holds a finished result.
- unit_res  in  N_UNITS×XLEN  result data per unit.
- unit_rd  in  N_UNITS×REG_ADDR_W  destination register per unit.
- unit_error  in  N_UNITS  result carries an error flag.
- unit_clear  out  N_UNITS  one-cycle acknowledge to the granted unit.
- wb_stall  in  1  register file busy; no grant this cycle.
- wr_en  out  1  register-file write strobe.
- wr_addr  out  REG_ADDR_W  write address.
- wr_data  out  XLEN  write data.
- exc_valid  out  1  one-cycle pulse: committed result was error-flagged.
- exc_unit  out  $clog2(N_UNITS)  index of the faulting unit.
- exc_rd  out  REG_ADDR_W  destination register of the faulting result.
- commit_cnt  out  32  present only with COMMIT_PERF_EN.
- conflict_cnt  out  32  present only with COMMIT_PERF_EN.

## Operation
- Eligible set: `elig = unit_valid & ~unit_clear`. Masking by the registered clear prevents granting the same result twice while the unit is still deasserting valid.
- Each cycle with `wb_stall == 0` and `elig != 0`, grant exactly one unit `w`: the first eligible unit at or after `rr_ptr`, searching upward modulo N_UNITS.
- On a grant:
  - `rr_ptr <= (w+1) mod N_UNITS`.
  - `unit_clear[w]` pulses high next cycle. All other clear bits stay 0.
  - If `unit_error[w]`: `exc_valid = 1`, `exc_unit = w`, `exc_rd = unit_rd[w]`, `wr_en = 0`.
  - Else if `unit_rd[w] == 0`: no write (x0 is hardwired), `exc_valid = 0`, clear still issued.
  - Else: `wr_en = 1`, `wr_addr = unit_rd[w]`, `wr_data = unit_res[w]`.
- No grant (stall or empty elig): `wr_en`, `exc_valid` and `unit_clear` are all 0 next cycle. `rr_ptr` holds. `wr_addr`, `wr_data`, `exc_unit` and `exc_rd` hold their last values.
- Reset values: `rr_ptr = 0`. `unit_clear`, `wr_en`, `wr_addr`, `wr_data`, `exc_valid`, `exc_unit` and `exc_rd` are all 0. Counters are 0.
- Reset mid-operation: all pending grants are dropped. No clear is issued, so units keep their results and are re-arbitrated after reset.

## Timing
- Latency is 1 cycle from `unit_valid` sampled high to `wr_en`/`exc_valid` plus `unit_clear`, all registered and asserted in the same cycle.
- Throughput is 1 commit per cycle when several units are valid.
- A unit needs 1 cycle after its clear to deassert valid. The clear mask covers that cycle, so back-to-back grants go to different units.
- `wb_stall` is sampled in the same cycle as arbitration. A stall asserted in cycle T suppresses the outputs in T+1 only.
- Fairness: with all N units continuously valid, each unit is granted exactly once per N cycles.

## Configuration
- COMMIT_PERF_EN defined:
  - `commit_cnt` increments on every `wr_en` cycle.
  - `conflict_cnt` increments on every cycle where `popcount(elig) > 1` and a grant occurs.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- COMMIT_PERF_EN undefined: both ports and both counters are absent.

## Structure
- core_config_pkg holds ALU_COUNT and the `unit_idx_t` typedef (`logic [$clog2(ALU_COUNT)-1:0]`).
- Sub-module `rr_arbiter`:
  - Combinational priority search.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: grant one-hot, grant index and `any_grant`.
- The top level holds `rr_ptr`, the output registers and the counters.

## Test plan
- Single unit: `unit_valid[1] = 1`, rd=5, res=0xDEADBEEF at T. At T+1, `wr_en = 1`, `wr_addr = 5`, `wr_data = 0xDEADBEEF`, `unit_clear = 4'b0010`. Unit drops valid at T+2, and no second write occurs.
- All 4 units valid continuously, `rr_ptr = 0`, clears not acted on by the model: grants follow 0,1,2,3,0 in successive cycles and no unit is granted while its clear is high.
- Error path: unit 2 valid with `unit_error = 1`, rd=7. Next cycle `exc_valid = 1`, `exc_unit = 2`, `exc_rd = 7`, `wr_en = 0`, `unit_clear = 4'b0100`.
- x0 destination: unit 0 valid with rd=0, res=0x1234. Next cycle `wr_en = 0`, `exc_valid = 0`, `unit_clear = 4'b0001`.
- Stall: units 0 and 3 valid, `wb_stall = 1` for 3 cycles, then low. No clears and no writes during the stall. First grant is unit 0 (`rr_ptr = 0`), then unit 3. With COMMIT_PERF_EN, `conflict_cnt = 1` and `commit_cnt = 2`.
- Reset mid-operation: `rst` asserted in the cycle unit 1 is granted. The outputs show no clear and no write, and `rr_ptr = 0`. After release, unit 1 (still valid) is committed one cycle later.

Source files
------------

// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the execution and commit stages:
// unit count, datapath width, register index width and the unit index type.
package core_config_pkg;

  localparam int ALU_COUNT  = 4;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int UNIT_IDX_W = $clog2(ALU_COUNT);

  typedef logic [UNIT_IDX_W-1:0] unit_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search. Picks the first requester at or after
// rr_ptr, wrapping modulo N. Returns a one-hot grant, its index and a
// flag saying whether anything was granted.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_grant
);

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin : search
    int idx;
    gnt       = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!any_grant && req[idx]) begin
        any_grant = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_commit_arbiter.sv
// Writeback/commit stage: picks one finished ALU result per cycle with
// round-robin fairness, writes it to the register file (or raises an
// exception for error-flagged results) and acknowledges the unit with a
// one-cycle clear. Optional performance counters are built when the
// COMMIT_PERF_EN macro is defined.
module alu_commit_arbiter
  import core_config_pkg::*;
#(
  parameter int N_UNITS    = ALU_COUNT,
  parameter int XLEN_P     = XLEN,
  parameter int REG_ADDR_P = REG_ADDR_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_UNITS-1:0]                  unit_valid,
  input  logic [N_UNITS-1:0][XLEN_P-1:0]      unit_res,
  input  logic [N_UNITS-1:0][REG_ADDR_P-1:0]  unit_rd,
  input  logic [N_UNITS-1:0]                  unit_error,
  output logic [N_UNITS-1:0]                  unit_clear,
  input  logic                                wb_stall,
  output logic                                wr_en,
  output logic [REG_ADDR_P-1:0]               wr_addr,
  output logic [XLEN_P-1:0]                   wr_data,
  output logic                                exc_valid,
  output logic [$clog2(N_UNITS)-1:0]          exc_unit,
  output logic [REG_ADDR_P-1:0]               exc_rd
`ifdef COMMIT_PERF_EN
  ,
  output logic [31:0]                         commit_cnt,
  output logic [31:0]                         conflict_cnt
`endif
);

  localparam int IDX_W = $clog2(N_UNITS);

  logic [N_UNITS-1:0]    elig;
  logic [N_UNITS-1:0]    gnt_onehot;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  any_grant;
  logic                  grant;
  logic [IDX_W-1:0]      rr_ptr_reg;
  logic [IDX_W-1:0]      rr_ptr_next;
  logic [REG_ADDR_P-1:0] sel_rd;
  logic [XLEN_P-1:0]     sel_res;
  logic                  sel_err;
  logic                  do_write;
  logic                  do_exc;

  // A unit whose clear is high is still dropping its valid, so it is
  // masked out to avoid committing the same result twice.
  genvar gi;
  generate
    for (gi = 0; gi < N_UNITS; gi++) begin : g_elig
      assign elig[gi] = unit_valid[gi] & ~unit_clear[gi];
    end
  endgenerate

  rr_arbiter #(.N(N_UNITS)) u_rr_arbiter (
    .req       (elig),
    .rr_ptr    (rr_ptr_reg),
    .gnt       (gnt_onehot),
    .gnt_idx   (gnt_idx),
    .any_grant (any_grant)
  );

  assign grant   = any_grant & ~wb_stall;
  assign sel_rd  = unit_rd[gnt_idx];
  assign sel_res = unit_res[gnt_idx];
  assign sel_err = unit_error[gnt_idx];

  // Error results go to the exception port; x0 writes are dropped silently.
  assign do_write = grant & ~sel_err & (sel_rd != '0);
  assign do_exc   = grant & sel_err;

  // Pointer moves just past the winner, wrapping at the last unit.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant) begin
      rr_ptr_next = (gnt_idx == IDX_W'(N_UNITS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Commit registers: strobes are recomputed every cycle, data fields hold
  // their last value until the next write or exception.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= '0;
      unit_clear <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      exc_valid  <= 1'b0;
      exc_unit   <= '0;
      exc_rd     <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      unit_clear <= grant ? gnt_onehot : '0;
      wr_en      <= do_write;
      exc_valid  <= do_exc;
      if (do_write) begin
        wr_addr <= sel_rd;
        wr_data <= sel_res;
      end
      if (do_exc) begin
        exc_unit <= gnt_idx;
        exc_rd   <= sel_rd;
      end
    end
  end

`ifdef COMMIT_PERF_EN
  logic conflict;

  assign conflict = grant & ($countones(elig) > 1);

  // Counters advance on the same edge that registers the commit they count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (do_write) commit_cnt <= commit_cnt + 32'd1;
      if (conflict) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_commit_arbiter.sv
// Self-checking bench for alu_commit_arbiter (default 4 units, 32-bit data).
// Vector table, hand-written multi-cycle sequences and a randomized run
// against a behavioural model of the commit rules.
module tb_alu_commit_arbiter;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      unit_valid;
  logic [3:0][31:0] unit_res;
  logic [3:0][4:0] unit_rd;
  logic [3:0]      unit_error;
  logic [3:0]      unit_clear;
  logic            wb_stall;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [31:0]     wr_data;
  logic            exc_valid;
  logic [1:0]      exc_unit;
  logic [4:0]      exc_rd;
`ifdef COMMIT_PERF_EN
  logic [31:0]     commit_cnt;
  logic [31:0]     conflict_cnt;
`endif

  alu_commit_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .unit_valid (unit_valid),
    .unit_res   (unit_res),
    .unit_rd    (unit_rd),
    .unit_error (unit_error),
    .unit_clear (unit_clear),
    .wb_stall   (wb_stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .exc_valid  (exc_valid),
    .exc_unit   (exc_unit),
    .exc_rd     (exc_rd)
`ifdef COMMIT_PERF_EN
    ,
    .commit_cnt   (commit_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_ptr;
  logic [3:0] m_clear;
  int         m_cc;
  int         m_conf;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    unit_valid = '0;
    unit_error = '0;
    unit_res   = '0;
    unit_rd    = '0;
    wb_stall   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    m_ptr   = 0;
    m_clear = '0;
    m_cc    = 0;
    m_conf  = 0;
  endtask

  // One clock with model prediction and full output comparison.
  task automatic tick(string nm);
    logic [3:0]  elig;
    int          w;
    int          nel;
    bit          g;
    bit          e_wr;
    bit          e_exc;
    logic [4:0]  e_rd;
    logic [31:0] e_res;
    elig = unit_valid & ~m_clear;
    nel  = $countones(elig);
    g    = 0;
    w    = 0;
    if (!wb_stall) begin
      for (int k = 0; k < 4; k++) begin
        if (!g && elig[(m_ptr + k) % 4]) begin
          g = 1;
          w = (m_ptr + k) % 4;
        end
      end
    end
    e_exc = g && unit_error[w];
    e_wr  = g && !unit_error[w] && (unit_rd[w] != 5'd0);
    e_rd  = unit_rd[w];
    e_res = unit_res[w];
    @(posedge clk);
    #1;
    m_clear = g ? 4'(1 << w) : 4'b0000;
    if (g) m_ptr = (w + 1) % 4;
    if (e_wr) m_cc++;
    if (g && nel > 1) m_conf++;
    chk({nm, ".clear"}, 32'(unit_clear), 32'(m_clear));
    chk({nm, ".wr_en"}, 32'(wr_en), 32'(e_wr));
    chk({nm, ".exc_valid"}, 32'(exc_valid), 32'(e_exc));
    if (e_wr) begin
      chk({nm, ".wr_addr"}, 32'(wr_addr), 32'(e_rd));
      chk({nm, ".wr_data"}, wr_data, e_res);
    end
    if (e_exc) begin
      chk({nm, ".exc_unit"}, 32'(exc_unit), 32'(w));
      chk({nm, ".exc_rd"}, 32'(exc_rd), 32'(e_rd));
    end
`ifdef COMMIT_PERF_EN
    chk({nm, ".commit_cnt"}, commit_cnt, 32'(m_cc));
    chk({nm, ".conflict_cnt"}, conflict_cnt, 32'(m_conf));
`endif
    if (g) $display("%s: commit unit=%0d rd=%0d err=%0b", nm, w, e_rd, e_exc);
  endtask

  typedef struct {
    logic [3:0]       valid;
    logic [3:0]       error;
    logic             stall;
    logic [3:0][4:0]  rd;
    logic [3:0][31:0] res;
    logic [3:0]       e_clear;
    logic             e_wr;
    logic [4:0]       e_addr;
    logic [31:0]      e_data;
    logic             e_exc;
    logic [1:0]       e_unit;
    logic [4:0]       e_rd;
  } vec_t;

  vec_t vt[8];

  initial begin
    rst        = 1'b1;
    unit_valid = '0;
    unit_error = '0;
    unit_res   = '0;
    unit_rd    = '0;
    wb_stall   = 1'b0;

    // Each vector starts from reset, so the pointer is 0.
    vt[0] = '{4'b0010, 4'b0000, 1'b0, {5'd0, 5'd0, 5'd5, 5'd0},
              {32'h0, 32'h0, 32'hDEADBEEF, 32'h0},
              4'b0010, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 2'd0, 5'd0};
    vt[1] = '{4'b0100, 4'b0100, 1'b0, {5'd0, 5'd7, 5'd0, 5'd0},
              {32'h0, 32'h55, 32'h0, 32'h0},
              4'b0100, 1'b0, 5'd0, 32'h0, 1'b1, 2'd2, 5'd7};
    vt[2] = '{4'b0001, 4'b0000, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0},
              {32'h0, 32'h0, 32'h0, 32'h1234},
              4'b0001, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 5'd0};
    vt[3] = '{4'b1001, 4'b0000, 1'b1, {5'd9, 5'd0, 5'd0, 5'd3},
              {32'h99, 32'h0, 32'h0, 32'h33},
              4'b0000, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 5'd0};
    vt[4] = '{4'b1010, 4'b0000, 1'b0, {5'd4, 5'd0, 5'd3, 5'd0},
              {32'h33, 32'h0, 32'h11, 32'h0},
              4'b0010, 1'b1, 5'd3, 32'h11, 1'b0, 2'd0, 5'd0};
    vt[5] = '{4'b0000, 4'b1111, 1'b0, {5'd1, 5'd2, 5'd3, 5'd4},
              {32'h1, 32'h2, 32'h3, 32'h4},
              4'b0000, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 5'd0};
    vt[6] = '{4'b1100, 4'b1000, 1'b0, {5'd9, 5'd0, 5'd0, 5'd0},
              {32'h77, 32'h66, 32'h0, 32'h0},
              4'b0100, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 5'd0};
    vt[7] = '{4'b1000, 4'b1000, 1'b0, {5'd31, 5'd0, 5'd0, 5'd0},
              {32'hABCD, 32'h0, 32'h0, 32'h0},
              4'b1000, 1'b0, 5'd0, 32'h0, 1'b1, 2'd3, 5'd31};

    // Reset state
    do_reset();
    chk("reset.clear", 32'(unit_clear), 32'h0);
    chk("reset.wr_en", 32'(wr_en), 32'h0);
    chk("reset.wr_addr", 32'(wr_addr), 32'h0);
    chk("reset.wr_data", wr_data, 32'h0);
    chk("reset.exc_valid", 32'(exc_valid), 32'h0);
    chk("reset.exc_unit", 32'(exc_unit), 32'h0);
    chk("reset.exc_rd", 32'(exc_rd), 32'h0);
`ifdef COMMIT_PERF_EN
    chk("reset.commit_cnt", commit_cnt, 32'h0);
    chk("reset.conflict_cnt", conflict_cnt, 32'h0);
`endif

    // Table-driven single-cycle vectors
    for (int i = 0; i < 8; i++) begin
      do_reset();
      unit_valid = vt[i].valid;
      unit_error = vt[i].error;
      wb_stall   = vt[i].stall;
      unit_rd    = vt[i].rd;
      unit_res   = vt[i].res;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.clear", i), 32'(unit_clear), 32'(vt[i].e_clear));
      chk($sformatf("vec%0d.wr_en", i), 32'(wr_en), 32'(vt[i].e_wr));
      chk($sformatf("vec%0d.exc_valid", i), 32'(exc_valid), 32'(vt[i].e_exc));
      if (vt[i].e_wr) begin
        chk($sformatf("vec%0d.wr_addr", i), 32'(wr_addr), 32'(vt[i].e_addr));
        chk($sformatf("vec%0d.wr_data", i), wr_data, vt[i].e_data);
      end
      if (vt[i].e_exc) begin
        chk($sformatf("vec%0d.exc_unit", i), 32'(exc_unit), 32'(vt[i].e_unit));
        chk($sformatf("vec%0d.exc_rd", i), 32'(exc_rd), 32'(vt[i].e_rd));
      end
      $display("vec%0d: valid=%b stall=%b clear=%b wr_en=%b exc=%b",
               i, vt[i].valid, vt[i].stall, unit_clear, wr_en, exc_valid);
    end

    // Single unit: valid stays up through the clear cycle, then drops.
    do_reset();
    unit_valid = 4'b0010;
    unit_rd[1] = 5'd5;
    unit_res[1] = 32'hDEADBEEF;
    tick("single.t1");
    chk("single.t1.wr_data", wr_data, 32'hDEADBEEF);
    tick("single.t2");
    chk("single.t2.no_rewrite", 32'(wr_en), 32'h0);
    unit_valid = 4'b0000;
    tick("single.t3");
    chk("single.t3.no_rewrite", 32'(wr_en), 32'h0);

    // All four units continuously valid: strict rotation 0,1,2,3,0,...
    do_reset();
    unit_valid = 4'b1111;
    for (int u = 0; u < 4; u++) begin
      unit_rd[u]  = 5'(u + 10);
      unit_res[u] = 32'(u * 32'h101);
    end
    for (int k = 0; k < 9; k++) begin
      tick($sformatf("rr.c%0d", k));
      chk($sformatf("rr.order%0d", k), 32'(unit_clear), 32'(1 << (k % 4)));
    end

    // Stall: units 0 and 3 wait three stalled cycles, then commit 0 then 3.
    do_reset();
    unit_valid = 4'b1001;
    unit_rd[0] = 5'd3;
    unit_rd[3] = 5'd9;
    unit_res[0] = 32'hA0;
    unit_res[3] = 32'hA3;
    wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick($sformatf("stall.s%0d", k));
      chk($sformatf("stall.s%0d.nowr", k), 32'(wr_en), 32'h0);
    end
    wb_stall = 1'b0;
    tick("stall.g0");
    chk("stall.g0.unit", 32'(unit_clear), 32'h1);
    tick("stall.g1");
    chk("stall.g1.unit", 32'(unit_clear), 32'h8);
    unit_valid = 4'b0000;
    tick("stall.idle");
`ifdef COMMIT_PERF_EN
    chk("stall.conflict_cnt", conflict_cnt, 32'd1);
    chk("stall.commit_cnt", commit_cnt, 32'd2);
`endif

    // Reset mid-operation drops the grant and returns the pointer to 0.
    do_reset();
    unit_valid = 4'b0010;
    unit_rd[1] = 5'd5;
    unit_res[1] = 32'h15;
    tick("rstmid.pre");
    unit_valid = 4'b1010;
    unit_rd[1] = 5'd6;
    unit_res[1] = 32'h16;
    unit_rd[3] = 5'd8;
    unit_res[3] = 32'h38;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid.clear", 32'(unit_clear), 32'h0);
    chk("rstmid.wr_en", 32'(wr_en), 32'h0);
    rst     = 1'b0;
    m_ptr   = 0;
    m_clear = '0;
    m_cc    = 0;
    m_conf  = 0;
    tick("rstmid.post");
    chk("rstmid.post.unit1", 32'(unit_clear), 32'h2);
    chk("rstmid.post.addr", 32'(wr_addr), 32'd6);

    // Randomized run: units drop valid after their clear and reload later.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int u = 0; u < 4; u++) begin
        if (!unit_valid[u] && ($urandom_range(0, 2) == 0)) begin
          unit_valid[u] = 1'b1;
          unit_error[u] = ($urandom_range(0, 7) == 0);
          unit_rd[u]    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          unit_res[u]   = $urandom;
        end
      end
      wb_stall = ($urandom_range(0, 4) == 0);
      tick($sformatf("rand%0d", c));
      unit_valid = unit_valid & ~unit_clear;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
